// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection controller family.
package traffic_pkg;

   // Controller phases; 3 bits leaves room for future phases.
   typedef enum logic [2:0] {
      ST_ALL_RED    = 3'd0,
      ST_RED_YELLOW = 3'd1,
      ST_GREEN      = 3'd2,
      ST_YELLOW     = 3'd3,
      ST_FLASH      = 3'd4
   } state_e;

   // Bit positions inside a per-approach lamp vector.
   localparam int LAMP_RED    = 0;
   localparam int LAMP_YELLOW = 1;
   localparam int LAMP_GREEN  = 2;
   localparam int LAMP_W      = 3;

   // Next approach index in round-robin order, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/traffic_rr_arbiter.sv
// Combinational round-robin picker: first demanding approach after the
// current one, with the current one searched last.
module traffic_rr_arbiter
   import traffic_pkg::*;
#(
   parameter int N_DIR = 2,
   parameter int DW    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
   input  logic [N_DIR-1:0] demand,
   input  logic [DW-1:0]    active_dir,
   output logic [DW-1:0]    next_dir,
   output logic             any_demand
);

   // Walk the ring starting one past active_dir; keep the first hit.
   always_comb begin
      int idx;
      next_dir   = active_dir;
      any_demand = 1'b0;
      idx        = int'(active_dir);
      for (int k = 0; k < N_DIR; k++) begin
         idx = rr_next(idx, N_DIR);
         if (!any_demand && demand[idx[DW-1:0]]) begin
            any_demand = 1'b1;
            next_dir   = idx[DW-1:0];
         end
      end
   end

endmodule

// File: rtl/traffic_intersection_controller.sv
// N-approach intersection controller: one approach served at a time,
// all-red clearance, demand-driven round robin, rest-on-green,
// latched pedestrian requests with walk, and flashing-yellow night mode.
module traffic_intersection_controller
   import traffic_pkg::*;
#(
   parameter int N_DIR        = 2,
   parameter int ALL_RED_T    = 2,
   parameter int RED_YELLOW_T = 1,
   parameter int GREEN_T      = 4,
   parameter int YELLOW_T     = 2,
   parameter int PED_T        = 2,
   parameter int FLASH_T      = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_DIR-1:0]         car_req,
   input  logic [N_DIR-1:0]         ped_req,
   input  logic                     flash_mode,
   output logic [N_DIR-1:0]         red,
   output logic [N_DIR-1:0]         yellow,
   output logic [N_DIR-1:0]         green,
   output logic [N_DIR-1:0]         walk,
   output logic [$clog2(N_DIR)-1:0] active_dir
);

   localparam int DW    = $clog2(N_DIR);
   localparam int T_M1  = (ALL_RED_T > RED_YELLOW_T) ? ALL_RED_T : RED_YELLOW_T;
   localparam int T_M2  = (T_M1 > GREEN_T) ? T_M1 : GREEN_T;
   localparam int T_M3  = (T_M2 > YELLOW_T) ? T_M2 : YELLOW_T;
   localparam int T_MAX = (T_M3 > FLASH_T) ? T_M3 : FLASH_T;
   localparam int CW    = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] ALL_RED_C    = CW'(ALL_RED_T);
   localparam logic [CW-1:0] RED_YELLOW_C = CW'(RED_YELLOW_T);
   localparam logic [CW-1:0] GREEN_C      = CW'(GREEN_T);
   localparam logic [CW-1:0] YELLOW_C     = CW'(YELLOW_T);
   localparam logic [CW-1:0] FLASH_C      = CW'(FLASH_T);
   // Walk is lit while the green counter is still above this value.
   localparam logic [CW-1:0] WALK_END_C   = CW'(GREEN_T - PED_T);
   localparam logic [DW-1:0] LAST_DIR     = DW'(N_DIR - 1);

   generate
      if (N_DIR < 2 || N_DIR > 8) begin : g_bad_ndir
         $error("traffic_intersection_controller: N_DIR must be in 2..8");
      end
      if (ALL_RED_T < 1 || RED_YELLOW_T < 1 || GREEN_T < 1 || YELLOW_T < 1 ||
          PED_T < 1 || FLASH_T < 1) begin : g_bad_time
         $error("traffic_intersection_controller: all durations must be >= 1");
      end
      if (PED_T > GREEN_T) begin : g_bad_ped
         $error("traffic_intersection_controller: PED_T must not exceed GREEN_T");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    dir_q, dir_d;
   logic [N_DIR-1:0] ped_pend_q, ped_pend_d;
   logic             walk_q, walk_d;
   logic             flash_on_q, flash_on_d;

   logic [N_DIR-1:0] demand;
   logic [N_DIR-1:0] dir_onehot;
   logic             other_demand;
   logic             expire;
   logic             walk_on;
   logic [DW-1:0]    next_dir;
   logic             any_demand;

   assign demand       = car_req | ped_pend_q;
   assign dir_onehot   = {{(N_DIR-1){1'b0}}, 1'b1} << dir_q;
   assign other_demand = |(demand & ~dir_onehot);
   assign expire       = (cnt_q == CW'(1));
   assign walk_on      = walk_q && (state_q == ST_GREEN) && (cnt_q > WALK_END_C);
   assign active_dir   = dir_q;

   traffic_rr_arbiter #(
      .N_DIR (N_DIR),
      .DW    (DW)
   ) u_arb (
      .demand     (demand),
      .active_dir (dir_q),
      .next_dir   (next_dir),
      .any_demand (any_demand)
   );

   // Next-state, timer reload and pedestrian latch logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q - CW'(1);
      dir_d      = dir_q;
      walk_d     = walk_q;
      flash_on_d = flash_on_q;
      // Presses are ignored on an approach whose walk lamp is already lit.
      ped_pend_d = ped_pend_q | (ped_req & ~walk);
      case (state_q)
         ST_ALL_RED: begin
            if (expire) begin
               if (flash_mode) begin
                  state_d    = ST_FLASH;
                  cnt_d      = FLASH_C;
                  flash_on_d = 1'b1;
               end else if (any_demand) begin
                  state_d = ST_RED_YELLOW;
                  cnt_d   = RED_YELLOW_C;
                  dir_d   = next_dir;
               end else begin
                  cnt_d = ALL_RED_C;
               end
            end
         end
         ST_RED_YELLOW: begin
            if (expire) begin
               state_d           = ST_GREEN;
               cnt_d             = GREEN_C;
               // Walk only if a request was already latched; entry consumes it.
               walk_d            = ped_pend_q[dir_q];
               ped_pend_d[dir_q] = 1'b0;
            end
         end
         ST_GREEN: begin
            if (expire) begin
               walk_d = 1'b0;
               if (flash_mode || other_demand) begin
                  state_d = ST_YELLOW;
                  cnt_d   = YELLOW_C;
               end else begin
                  cnt_d = GREEN_C;
               end
            end
         end
         ST_YELLOW: begin
            if (expire) begin
               state_d = ST_ALL_RED;
               cnt_d   = ALL_RED_C;
            end
         end
         ST_FLASH: begin
            if (!flash_mode) begin
               // Leave via all-red with approach 0 next in line.
               state_d    = ST_ALL_RED;
               cnt_d      = ALL_RED_C;
               dir_d      = LAST_DIR;
               flash_on_d = 1'b0;
            end else if (expire) begin
               cnt_d      = FLASH_C;
               flash_on_d = ~flash_on_q;
            end
         end
         default: begin
            state_d = ST_ALL_RED;
            cnt_d   = ALL_RED_C;
         end
      endcase
   end

   // State, timer, grant and pedestrian registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_ALL_RED;
         cnt_q      <= ALL_RED_C;
         dir_q      <= LAST_DIR;
         ped_pend_q <= '0;
         walk_q     <= 1'b0;
         flash_on_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         ped_pend_q <= ped_pend_d;
         walk_q     <= walk_d;
         flash_on_q <= flash_on_d;
      end
   end

   generate
      for (genvar gi = 0; gi < N_DIR; gi++) begin : g_lamp
         logic [LAMP_W-1:0] lamp;
         logic              is_active;

         assign is_active = (dir_q == DW'(gi));

         // Moore lamp decode for this approach.
         always_comb begin
            lamp           = '0;
            lamp[LAMP_RED] = 1'b1;
            if (state_q == ST_FLASH) begin
               lamp              = '0;
               lamp[LAMP_YELLOW] = flash_on_q;
            end else if (is_active) begin
               case (state_q)
                  ST_RED_YELLOW: begin
                     lamp[LAMP_RED]    = 1'b1;
                     lamp[LAMP_YELLOW] = 1'b1;
                  end
                  ST_GREEN: begin
                     lamp             = '0;
                     lamp[LAMP_GREEN] = 1'b1;
                  end
                  ST_YELLOW: begin
                     lamp              = '0;
                     lamp[LAMP_YELLOW] = 1'b1;
                  end
                  default: lamp[LAMP_RED] = 1'b1;
               endcase
            end
         end

         assign red[gi]    = lamp[LAMP_RED];
         assign yellow[gi] = lamp[LAMP_YELLOW];
         assign green[gi]  = lamp[LAMP_GREEN];
         assign walk[gi]   = walk_on && is_active;
      end
   endgenerate

endmodule
